// File: rtl/lsu_pkg.sv
// lsu shared types and constants.
// Access sizes follow the RISC-V load/store funct3 encoding.
package lsu_pkg;

  typedef enum logic [2:0] {
    LDST_B  = 3'b000,
    LDST_H  = 3'b001,
    LDST_W  = 3'b010,
    LDST_BU = 3'b100,
    LDST_HU = 3'b101
  } ldst_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Size/alignment combinations the RAM port can serve.
  function automatic logic ldst_legal(
    input logic [2:0] size,
    input logic [1:0] off
  );
    case (size)
      LDST_B, LDST_BU: return 1'b1;
      LDST_H, LDST_HU: return !off[0];
      LDST_W:          return off == 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu data RAM bus.
// master = load/store unit, slave = RAM.
interface lsu_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output req, we, be, adr, wdata,
    input  rdata
  );

  modport slave (
    input  req, we, be, adr, wdata,
    output rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu load alignment.
// Picks the addressed lane and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] data_rdata_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] core_rd_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign/zero extension.
  always_comb begin
    byte_sel  = data_rdata_i[{offset_i, 3'b000} +: 8];
    half_sel  = offset_i[1] ? data_rdata_i[31:16]
                            : data_rdata_i[15:0];
    core_rd_o = data_rdata_i;
    case (size_i)
      LDST_B:  core_rd_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: core_rd_o = {24'h0, byte_sel};
      LDST_H:  core_rd_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: core_rd_o = {16'h0, half_sel};
      default: core_rd_o = data_rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu top: request FSM, legality, store lanes.
// One stalled request cycle, then a completion cycle.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  lsu_if.master       data
);

  lsu_state_e  state_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic        legal;
  logic        idle_req;
  logic        accept;

  // Accept only from IDLE; reset gates the strobes at once.
  always_comb begin
    legal    = ldst_legal(core_size_i, core_addr_i[1:0]);
    idle_req = rst_n_i && (state_q == ST_IDLE) && core_req_i;
    accept   = idle_req && legal;
  end

  // Request FSM and capture of the load lane fields.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      size_q  <= 3'b000;
      off_q   <= 2'b00;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_WAIT;
            size_q  <= core_size_i;
            off_q   <= core_addr_i[1:0];
          end
        end
        ST_WAIT: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus strobes, byte enables and lane-replicated store data.
  always_comb begin
    core_stall_o = accept;
    misalign_o   = idle_req && !legal;
    data.req     = accept;
    data.we      = accept && core_we_i;
    data.adr     = {core_addr_i[31:2], 2'b00};
    data.be      = BE_WORD;
    data.wdata   = core_wd_i;
    if (core_we_i) begin
      case (core_size_i[1:0])
        2'b00: begin
          data.be    = BE_BYTE << core_addr_i[1:0];
          data.wdata = {4{core_wd_i[7:0]}};
        end
        2'b01: begin
          data.be    = core_addr_i[1] ? (BE_HALF << 2) : BE_HALF;
          data.wdata = {2{core_wd_i[15:0]}};
        end
        default: begin
          data.be    = BE_WORD;
          data.wdata = core_wd_i;
        end
      endcase
    end
  end

  lsu_load_align u_align (
    .data_rdata_i (data.rdata),
    .size_i       (size_q),
    .offset_i     (off_q),
    .core_rd_o    (core_rd_o)
  );

endmodule

// File: tb/tb_lsu.sv
// lsu bench: RAM model, shadow memory, load scoreboard.
// Also exercises lsu_load_align on its own.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'b000;
  logic [31:0] core_addr_i = 32'h0;
  logic [31:0] core_wd_i = 32'h0;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        misalign_o;

  lsu_if bus ();

  lsu dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .misalign_o   (misalign_o),
    .data         (bus)
  );

  logic [31:0] ua_rdata = 32'h0;
  logic [2:0]  ua_size = 3'b000;
  logic [1:0]  ua_off = 2'b00;
  logic [31:0] ua_rd;

  lsu_load_align u_ua (
    .data_rdata_i (ua_rdata),
    .size_i       (ua_size),
    .offset_i     (ua_off),
    .core_rd_o    (ua_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic [31:0] shadow [64];
  logic [31:0] rdata_q = 32'h0000_0080;
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  assign bus.rdata = rdata_q;

  always @(posedge clk) begin
    if (bus.req) begin
      for (int i = 0; i < 4; i++)
        if (bus.we && bus.be[i])
          mem[bus.adr[7:2]][8*i +: 8] <= bus.wdata[8*i +: 8];
      rdata_q <= mem[bus.adr[7:2]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic legal_m(input logic [2:0] sz,
                                   input logic [1:0] a);
    if (sz == 3'd0 || sz == 3'd4) return 1'b1;
    if (sz == 3'd1 || sz == 3'd5) return a[0] == 1'b0;
    if (sz == 3'd2) return a == 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] sz,
                                           input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * a);
    h = w >> (16 * a[1]);
    case (sz)
      3'd0: return {{24{b[7]}}, b[7:0]};
      3'd4: return b & 32'hFF;
      3'd1: return {{16{h[15]}}, h[15:0]};
      3'd5: return h & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  // Issue one request; legal ones occupy a second (WAIT) cycle.
  task automatic do_req(input logic we,
                        input logic [2:0] sz,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input string tag);
    logic ok;
    logic [3:0] ebe;
    logic [31:0] ewd;
    int idx;
    ok  = legal_m(sz, a[1:0]);
    idx = int'(a[7:2]);
    ebe = 4'hF;
    ewd = wd;
    if (we && sz[1:0] == 2'b00) begin
      ebe = 4'(1 << a[1:0]);
      ewd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
    end else if (we && sz[1:0] == 2'b01) begin
      ebe = a[1] ? 4'hC : 4'h3;
      ewd = {wd[15:0], wd[15:0]};
    end
    @(negedge clk);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = a;
    core_wd_i   = wd;
    #1;
    chk({tag, ":stall"}, 32'(core_stall_o), 32'(ok));
    chk({tag, ":req"}, 32'(bus.req), 32'(ok));
    chk({tag, ":misalign"}, 32'(misalign_o), 32'(!ok));
    if (!ok) begin
      chk({tag, ":we"}, 32'(bus.we), 32'(0));
      return;
    end
    chk({tag, ":adr"}, bus.adr, a & 32'hFFFF_FFFC);
    chk({tag, ":we"}, 32'(bus.we), 32'(we));
    chk({tag, ":be"}, 32'(bus.be), 32'(ebe));
    if (we) begin
      chk({tag, ":wdata"}, bus.wdata, ewd);
      for (int i = 0; i < 4; i++)
        if (ebe[i]) shadow[idx][8*i +: 8] = ewd[8*i +: 8];
    end else begin
      exp_q.push_back(ref_load(sz, a[1:0], shadow[idx]));
    end
    @(negedge clk);
    #1;
    chk({tag, ":wstall"}, 32'(core_stall_o), 32'(0));
    chk({tag, ":wreq"}, 32'(bus.req), 32'(0));
    if (!we) begin
      if (exp_q.size() == 0) chk({tag, ":sbempty"}, 32'(1), 32'(0));
      else chk({tag, ":rd"}, core_rd_o, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [2:0] sizes [5];
    logic [2:0] sz;
    logic [1:0] off;
    logic [31:0] a;
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;

    #3;
    chk("rst:stall", 32'(core_stall_o), 32'(0));
    chk("rst:req", 32'(bus.req), 32'(0));
    chk("rst:misalign", 32'(misalign_o), 32'(0));
    chk("rst:rd", core_rd_o, 32'hFFFF_FF80);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b1, 3'd0, 32'h0000_0103, 32'h1234_56AB, "sb");
    do_req(1'b1, 3'd1, 32'h0000_0042, 32'h0000_BEEF, "sh");
    do_req(1'b1, 3'd2, 32'h0000_0040, 32'h80FF_7F01, "sw40");
    do_req(1'b0, 3'd0, 32'h0000_0043, 32'h0, "lb43");
    do_req(1'b0, 3'd4, 32'h0000_0043, 32'h0, "lbu43");
    do_req(1'b0, 3'd1, 32'h0000_0040, 32'h0, "lh40");
    do_req(1'b0, 3'd5, 32'h0000_0042, 32'h0, "lhu42");
    do_req(1'b0, 3'd2, 32'h0000_0040, 32'h0, "lw40");
    chk("tp:sbword", shadow[16], 32'h80FF_7F01);
    do_req(1'b0, 3'd2, 32'h0000_0041, 32'h0, "lw41");
    do_req(1'b0, 3'd1, 32'h0000_0043, 32'h0, "lh43");
    do_req(1'b0, 3'd3, 32'h0000_0040, 32'h0, "sz3");
    do_req(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, "sw10");
    do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, "lw10");

    // Reset in the WAIT cycle of a load, request still held.
    @(negedge clk);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0000_0040;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst:stall", 32'(core_stall_o), 32'(0));
    chk("arst:req", 32'(bus.req), 32'(0));
    @(negedge clk);
    core_req_i = 1'b0;
    rst_n = 1'b1;
    do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, "postrst");

    for (int i = 0; i < 12; i++) begin
      a = 32'h0000_0080 + 32'(4 * i);
      do_req(1'b1, 3'd2, a, $urandom, "rsw");
      sz  = sizes[$urandom_range(0, 1)];
      off = 2'($urandom_range(0, 3));
      if (sz == 3'd1) off[0] = 1'b0;
      do_req(1'b1, sz, a | 32'(off), $urandom, "rst_sub");
      sz  = sizes[$urandom_range(0, 4)];
      off = 2'($urandom_range(0, 3));
      if (sz[0]) off[0] = 1'b0;
      if (sz == 3'd2) off = 2'b00;
      do_req(1'b0, sz, a | 32'(off), 32'h0, "rld");
    end
    @(negedge clk);
    core_req_i = 1'b0;

    for (int s = 0; s < 5; s++) begin
      for (int o = 0; o < 4; o++) begin
        ua_rdata = $urandom;
        ua_size  = sizes[s];
        ua_off   = 2'(o);
        #1;
        chk("align", ua_rd, ref_load(ua_size, ua_off, ua_rdata));
      end
    end
    ua_rdata = 32'h8000_8080;
    ua_size  = 3'd1;
    ua_off   = 2'd2;
    #1;
    chk("align:h_hi", ua_rd, 32'hFFFF_8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the core's data memory interface. It sits between the single-cycle core datapath and data RAM. It turns core load/store requests of size byte, half or word into word-addressed RAM transactions with byte enables and lane-aligned write data. It sign- or zero-extends returned read data and stalls the core for the one cycle of synchronous-read latency.

## Interface
- No parameters; address and data widths are fixed at 32.
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- core_req_i  in  1  core requests a memory access this cycle
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, right-aligned
- core_rd_o  out  32  load result, extended
- core_stall_o  out  1  hold PC and register writeback
- misalign_o  out  1  one-cycle pulse: illegal alignment or size, request dropped
- data_req_o  out  1  RAM access strobe
- data_we_o  out  1  RAM write enable
- data_be_o  out  4  byte enables, bit n = byte lane n
- data_adr_o  out  32  byte address with bits [1:0] forced to 0
- data_wdata_o  out  32  lane-replicated write data
- data_rdata_i  in  32  RAM read word, valid the cycle after data_req_o

## Operation
- FSM states IDLE and WAIT. The reset state is IDLE.
- **IDLE, core_req_i=1, legal request:**
  - data_req_o=1 and core_stall_o=1.
  - Capture size and addr[1:0] into registers.
  - Go to WAIT.
- **IDLE, core_req_i=1, illegal request:**
  - Illegal means H/HU with addr[0]=1, W with addr[1:0]≠0, or size 011/110/111.
  - misalign_o=1, data_req_o=0, core_stall_o=0. Stay in IDLE.
- **WAIT:**
  - data_req_o=0 and core_stall_o=0.
  - core_rd_o is formed from data_rdata_i and the captured fields.
  - Return to IDLE unconditionally. A core_req_i seen in WAIT is the same instruction retiring and is ignored.
- **Byte enables (data_be_o) for stores:**
  - B: 0001 shifted left by addr[1:0].
  - H: 0011 if addr[1]=0, else 1100.
  - W: 1111.
  - For loads data_be_o = 1111.
- **data_wdata_o:**
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- **Load extraction:**
  - Select the byte addressed by offset, or the halfword addressed by offset[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- data_we_o = core_we_i, gated by data_req_o.
- Outputs are combinational from state, captured registers and inputs. The only registers are the state bit, captured size (3 bits) and captured offset (2 bits).

## Timing
- Every legal access takes 2 cycles: request cycle (stalled), then completion cycle.
- Store: the RAM writes on the rising edge that ends the request cycle.
- Load: core_rd_o is valid throughout the WAIT cycle, for register-file writeback on the edge that ends it.
- Back-to-back memory instructions: a new request is accepted in the IDLE cycle directly after WAIT. Sustained throughput is one access per 2 cycles.
- **Reset values:**
  - state=IDLE, captured size=000, captured offset=00.
  - data_req_o=0, core_stall_o=0, misalign_o=0 when core_req_i=0.
  - core_rd_o = sign-extended byte 0 of data_rdata_i.
- **Reset asserted in WAIT:** state returns to IDLE immediately and no stall is issued. A store already launched has completed at the RAM edge; a load result is discarded.
- core_stall_o never stays high for more than 1 consecutive cycle.

## Structure
- Shared package lsu_pkg:
  - typedef enum for size (LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU).
  - typedef enum for FSM state.
  - Byte-enable constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111.
- One natural sub-module: lsu_load_align, purely combinational. Inputs: data_rdata_i, captured size, captured offset. Output: core_rd_o. It gets its own unit test.
- The top level holds the FSM, legality check, store byte-enable generation and write-data replication.

## Test plan
- SB, addr 0x0000_0103, wd 0x1234_56AB → data_be_o=1000, data_wdata_o=0xABABABAB, data_adr_o=0x0000_0100, stall for 1 cycle.
- SH, addr 0x0000_0042, wd 0x0000_BEEF → data_be_o=1100, data_wdata_o=0xBEEF_BEEF.
- RAM word 0x80FF_7F01 at 0x40:
  - LB 0x43 → 0xFFFF_FF80.
  - LBU 0x43 → 0x0000_0080.
  - LH 0x40 → 0x0000_7F01.
  - LHU 0x42 → 0x0000_80FF.
  - LW 0x40 → 0x80FF_7F01.
- LW at 0x41 and LH at 0x43 → misalign_o=1, data_req_o=0, no stall, FSM stays IDLE.
- Back-to-back SW 0x10 ← 0xDEAD_BEEF then LW 0x10 → read returns 0xDEAD_BEEF. Stall pattern is 1,0,1,0.
- rst_n_i pulled low mid-cycle during WAIT of a load → core_stall_o=0 and data_req_o=0 asynchronously. Next request is accepted normally after release.
